// File: rtl/cmd_decoder_q.sv
// cmd_decoder_q: assembles UART bytes into command words, splits them into
// opcode/operand fields and buffers up to DEPTH commands for the ALU, which
// takes them with a cmd_valid/cmd_ack handshake.
// Optional feature: define CMD_TIMEOUT_EN to discard partial multi-byte
// commands after TIMEOUT_CYC idle cycles (reported on timeout_err).
module cmd_decoder_q #(
  parameter int OPC_W       = 2,
  parameter int OPD_W       = 3,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int W          = OPC_W + 2 * OPD_W,
  localparam int NB         = (W + 7) / 8,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             cmd_ack,
  output logic [OPC_W-1:0] opcode,
  output logic [OPD_W-1:0] operand1,
  output logic [OPD_W-1:0] operand2,
  output logic             cmd_valid,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [IW-1:0]   byte_idx;
  logic [NB*8-1:0] asm_word;   // earlier bytes above the byte arriving now
  logic [W-1:0]    word;
  logic            complete;
  logic            push;
  logic            pop;
  logic            tmo_fire;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [W-1:0]    head;

  // Byte assembly: the first byte received ends up most significant.
  generate
    if (NB == 1) begin : g_single
      assign asm_word = rx_data;
    end else begin : g_multi
      logic [(NB-1)*8-1:0] prev_q;

      // Keep the bytes received so far for the command being assembled.
      always_ff @(posedge clk) begin
        if (!reset) begin
          prev_q <= '0;
        end else if (rx_valid) begin
          prev_q <= asm_word[(NB-1)*8-1:0];
        end
      end

      assign asm_word = {prev_q, rx_data};
    end
  endgenerate

  assign word      = asm_word[W-1:0];
  assign complete  = rx_valid && (byte_idx == LAST_IDX);
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid && cmd_ack;
  assign push      = complete && ((level != FULL_LVL) || pop);

  // Byte index: advances on every strobe, wraps after the last byte, and is
  // cleared when a partial command times out.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge, independent of block ordering.
    if (!reset) begin
      byte_idx <= '0;
    end else if (rx_valid) begin
      byte_idx <= complete ? '0 : byte_idx + 1'b1;
    end else if (tmo_fire) begin
      byte_idx <= '0;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] tmo_cnt;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_fire = !rx_valid && (byte_idx != '0) && (tmo_cnt == TMO_LAST);

  // Idle-cycle counter, running only while a command is partially assembled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (rx_valid || (byte_idx == '0) || tmo_fire) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  // Without the counter a partial command waits indefinitely; TIMEOUT_CYC
  // is referenced only so the parameter stays connected in this build.
  assign tmo_fire    = 1'b0;
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif

  // Queue storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; level/pointers define which
    // entries are live and the outputs are masked while the queue is empty.
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Queue bookkeeping: pointers, fill level and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= complete && !push;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  assign head     = mem[rd_ptr];
  assign opcode   = cmd_valid ? head[W-1 -: OPC_W]       : '0;
  assign operand2 = cmd_valid ? head[2*OPD_W-1 : OPD_W]  : '0;
  assign operand1 = cmd_valid ? head[OPD_W-1:0]          : '0;

endmodule

// File: tb/tb_cmd_decoder_q.sv
// Testbench for cmd_decoder_q: a default single-byte instance driven from a
// vector table, and a two-byte instance (OPC_W=4, OPD_W=6) exercised with
// hand-written sequences for reset, multi-byte assembly and timeout.
module tb_cmd_decoder_q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Default instance signals
  logic       reset_d;
  logic [7:0] d_rx_data;
  logic       d_rx_valid;
  logic       d_ack;
  logic [1:0] d_opcode;
  logic [2:0] d_op1, d_op2;
  logic       d_valid;
  logic [2:0] d_level;
  logic       d_ovf, d_tmo;

  // Wide instance signals
  logic       reset_w;
  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic       w_ack;
  logic [3:0] w_opcode;
  logic [5:0] w_op1, w_op2;
  logic       w_valid;
  logic [1:0] w_level;
  logic       w_ovf, w_tmo;

  cmd_decoder_q u_def (
    .clk         (clk),
    .reset       (reset_d),
    .rx_data     (d_rx_data),
    .rx_valid    (d_rx_valid),
    .cmd_ack     (d_ack),
    .opcode      (d_opcode),
    .operand1    (d_op1),
    .operand2    (d_op2),
    .cmd_valid   (d_valid),
    .level       (d_level),
    .overflow    (d_ovf),
    .timeout_err (d_tmo)
  );

  cmd_decoder_q #(
    .OPC_W       (4),
    .OPD_W       (6),
    .DEPTH       (2),
    .TIMEOUT_CYC (10)
  ) u_wide (
    .clk         (clk),
    .reset       (reset_w),
    .rx_data     (w_rx_data),
    .rx_valid    (w_rx_valid),
    .cmd_ack     (w_ack),
    .opcode      (w_opcode),
    .operand1    (w_op1),
    .operand2    (w_op2),
    .cmd_valid   (w_valid),
    .level       (w_level),
    .overflow    (w_ovf),
    .timeout_err (w_tmo)
  );

  typedef struct {
    logic       rv;
    logic [7:0] d;
    logic       ack;
    logic       ev;
    logic [1:0] opc;
    logic [2:0] op2;
    logic [2:0] op1;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic rv, input logic [7:0] d, input logic ack,
                       input logic ev, input logic [1:0] opc, input logic [2:0] op2,
                       input logic [2:0] op1, input logic [2:0] lvl, input logic ovf);
    vec_t v;
    v.rv = rv; v.d = d; v.ack = ack; v.ev = ev; v.opc = opc;
    v.op2 = op2; v.op1 = op1; v.lvl = lvl; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  // One cycle on the wide instance; inputs drop back to idle afterwards.
  task automatic w_step(input logic rv, input logic [7:0] d, input logic ack);
    w_rx_valid = rv;
    w_rx_data  = d;
    w_ack      = ack;
    @(posedge clk);
    #1;
    w_rx_valid = 1'b0;
    w_rx_data  = 8'h00;
    w_ack      = 1'b0;
  endtask

  task automatic w_expect(input string tag, input logic ev, input logic [3:0] opc,
                          input logic [5:0] op2, input logic [5:0] op1, input logic [1:0] lvl);
    check({tag, " cmd_valid"}, w_valid, ev);
    check({tag, " opcode"}, w_opcode, opc);
    check({tag, " operand2"}, w_op2, op2);
    check({tag, " operand1"}, w_op1, op1);
    check({tag, " level"}, w_level, lvl);
  endtask

  initial begin
    logic exp_tmo;

    reset_d = 1'b0; reset_w = 1'b0;
    d_rx_valid = 1'b0; d_rx_data = 8'h00; d_ack = 1'b0;
    w_rx_valid = 1'b0; w_rx_data = 8'h00; w_ack = 1'b0;

    // Table: inputs for one edge, then expected outputs after that edge.
    //     rv  data   ack  valid opc op2 op1 lvl ovf
    add_v(1, 8'hAB, 0,   1,  2,  5,  3,  1,  0);  // 10_101_011
    add_v(0, 8'h00, 0,   1,  2,  5,  3,  1,  0);  // head held without ack
    add_v(0, 8'h00, 1,   0,  0,  0,  0,  0,  0);  // popped, fields zero
    add_v(0, 8'h00, 1,   0,  0,  0,  0,  0,  0);  // ack on empty ignored
    add_v(1, 8'h01, 0,   1,  0,  0,  1,  1,  0);
    add_v(1, 8'h02, 0,   1,  0,  0,  1,  2,  0);
    add_v(1, 8'h03, 0,   1,  0,  0,  1,  3,  0);
    add_v(1, 8'h04, 0,   1,  0,  0,  1,  4,  0);
    add_v(1, 8'h05, 0,   1,  0,  0,  1,  4,  1);  // full: dropped
    add_v(0, 8'h00, 0,   1,  0,  0,  1,  4,  0);  // pulse is one cycle
    add_v(0, 8'h00, 1,   1,  0,  0,  2,  3,  0);
    add_v(0, 8'h00, 1,   1,  0,  0,  3,  2,  0);
    add_v(0, 8'h00, 1,   1,  0,  0,  4,  1,  0);
    add_v(0, 8'h00, 1,   0,  0,  0,  0,  0,  0);  // 0x05 never stored
    add_v(1, 8'h40, 0,   1,  1,  0,  0,  1,  0);
    add_v(1, 8'h88, 0,   1,  1,  0,  0,  2,  0);
    add_v(1, 8'hC7, 0,   1,  1,  0,  0,  3,  0);
    add_v(1, 8'h3F, 0,   1,  1,  0,  0,  4,  0);
    add_v(1, 8'hFF, 1,   1,  2,  1,  0,  4,  0);  // full + push + pop
    add_v(0, 8'h00, 1,   1,  3,  0,  7,  3,  0);
    add_v(0, 8'h00, 1,   1,  0,  7,  7,  2,  0);
    add_v(0, 8'h00, 1,   1,  3,  7,  7,  1,  0);  // 0xFF popped last
    add_v(0, 8'h00, 1,   0,  0,  0,  0,  0,  0);
    add_v(1, 8'h55, 0,   1,  1,  2,  5,  1,  0);
    add_v(1, 8'hAA, 1,   1,  2,  5,  2,  1,  0);  // push+pop at level 1
    add_v(0, 8'h00, 1,   0,  0,  0,  0,  0,  0);

    repeat (2) @(posedge clk);
    #1;
    check("reset d cmd_valid", d_valid, 1'b0);
    check("reset d level", d_level, 3'd0);
    check("reset d opcode", d_opcode, 2'd0);
    check("reset d overflow", d_ovf, 1'b0);
    check("reset d timeout_err", d_tmo, 1'b0);
    w_expect("reset w", 0, 4'h0, 6'h00, 6'h00, 2'd0);
    check("reset w timeout_err", w_tmo, 1'b0);
    reset_d = 1'b1;
    reset_w = 1'b1;

    // Table-driven run on the default instance.
    for (int i = 0; i < vecs.size(); i++) begin
      d_rx_valid = vecs[i].rv;
      d_rx_data  = vecs[i].d;
      d_ack      = vecs[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("v%0d cmd_valid", i), d_valid, vecs[i].ev);
      check($sformatf("v%0d opcode", i), d_opcode, vecs[i].opc);
      check($sformatf("v%0d operand2", i), d_op2, vecs[i].op2);
      check($sformatf("v%0d operand1", i), d_op1, vecs[i].op1);
      check($sformatf("v%0d level", i), d_level, vecs[i].lvl);
      check($sformatf("v%0d overflow", i), d_ovf, vecs[i].ovf);
    end
    d_rx_valid = 1'b0;
    d_ack      = 1'b0;

    // Two-byte assembly: first byte alone pushes nothing; opcode is the top
    // nibble of the first byte.
    w_step(1, 8'hA5, 0);
    w_expect("w one byte", 0, 4'h0, 6'h00, 6'h00, 2'd0);
    w_step(1, 8'h3C, 0);
    w_expect("w A53C", 1, 4'hA, 6'h14, 6'h3C, 2'd1);

    // Reset mid-command with a queued entry: both are discarded.
    w_step(1, 8'h77, 0);
    w_expect("w partial", 1, 4'hA, 6'h14, 6'h3C, 2'd1);
    reset_w = 1'b0;
    w_step(0, 8'h00, 0);
    reset_w = 1'b1;
    w_expect("w after reset", 0, 4'h0, 6'h00, 6'h00, 2'd0);
    w_step(1, 8'h12, 0);
    w_expect("w 12 alone", 0, 4'h0, 6'h00, 6'h00, 2'd0);
    w_step(1, 8'h34, 0);
    w_expect("w 1234", 1, 4'h1, 6'h08, 6'h34, 2'd1);
    w_step(0, 8'h00, 1);
    w_expect("w drain 1234", 0, 4'h0, 6'h00, 6'h00, 2'd0);

    // Inter-byte timeout: one byte, then ten idle cycles.
    w_step(1, 8'h99, 0);
    for (int i = 1; i <= 10; i++) begin
      w_step(0, 8'h00, 0);
      exp_tmo = 1'b0;
`ifdef CMD_TIMEOUT_EN
      exp_tmo = (i == 10);
`endif
      check($sformatf("w idle %0d timeout_err", i), w_tmo, exp_tmo);
    end
    check("w idle level", w_level, 2'd0);
`ifdef CMD_TIMEOUT_EN
    w_step(0, 8'h00, 0);
    check("w timeout pulse end", w_tmo, 1'b0);
    w_step(1, 8'h56, 0);
    w_expect("w 56 fresh", 0, 4'h0, 6'h00, 6'h00, 2'd0);
    w_step(1, 8'h78, 0);
    w_expect("w 5678", 1, 4'h5, 6'h19, 6'h38, 2'd1);
`else
    w_step(1, 8'h56, 0);
    w_expect("w 9956", 1, 4'h9, 6'h25, 6'h16, 2'd1);
`endif
    w_step(0, 8'h00, 1);
    w_expect("w drain", 0, 4'h0, 6'h00, 6'h00, 2'd0);

    // Second byte exactly on the expiry cycle is still accepted.
    w_step(1, 8'h11, 0);
    repeat (9) w_step(0, 8'h00, 0);
    w_step(1, 8'h22, 0);
    check("w expiry-cycle timeout_err", w_tmo, 1'b0);
    w_expect("w 1122", 1, 4'h1, 6'h04, 6'h22, 2'd1);
    w_step(0, 8'h00, 1);
    w_expect("w final drain", 0, 4'h0, 6'h00, 6'h00, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
